niu32_mmio: RTL and testbench
=============================

NIU32_MMIO -- requirements
Module: niu32_mmio

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: the number of consecutive stable synchronized cycles needed before a key state change is accepted; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port addr, input, 32 bits: CPU memory address, taken from the MAR.
REQ-005 SHALL have port wdata, input, 32 bits: CPU store data, taken from the bus.
REQ-006 SHALL have port we, input, 1 bit: write strobe, 1 cycle per store.
REQ-007 SHALL have port re, input, 1 bit: read strobe, 1 cycle per load.
REQ-008 SHALL have port rdata, output, 32 bits: registered read data.
REQ-009 SHALL have port rvalid, output, 1 bit: 1-cycle pulse marking rdata as valid.
REQ-010 SHALL have port io_sel, output, 1 bit: combinational, 1 when addr[31:16]==16'hFFFF, so the CPU can suppress dmem access.
REQ-011 SHALL have port key_n, input, 4 bits: raw, asynchronous, active-low board keys.
REQ-012 SHALL have port sw, input, 10 bits: raw, asynchronous board switches.
REQ-013 SHALL have port hex_val, output, 16 bits: 4 nibbles driving the seven-segment decoders (HEX0 = [3:0] ... HEX3 = [15:12]).
REQ-014 SHALL have port ledr, output, 10 bits: red LEDs.
REQ-015 SHALL have port ledg, output, 8 bits: green LEDs.

Function
REQ-016 SHALL decode the following register map, full 32-bit compare:
- FFFF0000 HEX: R/W, bits [15:0]
- FFFF0020 LEDR: R/W, bits [9:0]
- FFFF0040 LEDG: R/W, bits [7:0]
- FFFF0100 KEY: RO, debounced pressed state, 1 = pressed, bits [3:0]
- FFFF0104 KEY_EDGE: sticky press flags, write-1-to-clear, bits [3:0]
- FFFF0120 SWITCH: RO, synchronized, bits [9:0]
REQ-017 SHALL, on we, capture the low bits of wdata into the addressed R/W register at the clock edge; upper bits SHALL be discarded.
REQ-018 SHALL ignore writes to RO or unmapped addresses, with no state change.
REQ-019 SHALL, on re, return rdata zero-extended with rvalid=1 on the next cycle (latency 1); otherwise rvalid=0 and rdata holds its last value.
REQ-020 SHALL, for a read of an unmapped address, return rdata=0 with rvalid=1.
REQ-021 SHALL, when we and re are asserted in the same cycle to the same register, return the pre-write value in rdata.
REQ-022 SHALL pass key_n and sw each through a 2-flop synchronizer before any use; the SWITCH register SHALL be the synchronized value.
REQ-023 SHALL run a per-key debounce FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
- RELEASED -> PRESS_WAIT when the synchronized key is low, with the counter cleared.
- PRESS_WAIT -> PRESSED when the counter reaches DEBOUNCE_CYCLES-1 with the key still low; -> RELEASED if the key goes high.
- PRESSED and RELEASE_WAIT mirror these transitions for release.
- The counter SHALL increment once per cycle in the WAIT states and be 16 bits wide.
REQ-024 SHALL drive KEY bit n to 1 only in PRESSED or RELEASE_WAIT.
REQ-025 SHALL make each key's press transition a PRESS_WAIT->PRESSED event.
REQ-026 SHALL keep the 4 debounce FSMs independent; simultaneous events on several keys are all handled in the same cycle.

Reset
REQ-027 SHALL, while reset=1, asynchronously force hex_val, ledr, ledg, rdata, rvalid, KEY_EDGE and all counters to 0.
REQ-028 SHALL, while reset=1, force the synchronizer flops to the released state (1) for key_n and 0 for sw, and force the FSMs to RELEASED.
REQ-029 SHALL drop any read in flight when reset is asserted mid-transaction; rvalid SHALL not pulse for it after reset deasserts.
REQ-030 SHALL resume normal operation on the first clock edge after reset deasserts.

Configuration
REQ-031 SHALL gate the KEY_EDGE register and its logic with macro NIU32_MMIO_EDGE_EN.
REQ-032 SHALL, with NIU32_MMIO_EDGE_EN defined:
- Each press event SHALL set KEY_EDGE[n].
- A write with wdata[n]=1 SHALL clear KEY_EDGE[n].
- When a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-033 SHALL, without NIU32_MMIO_EDGE_EN defined, generate no KEY_EDGE flops; FFFF0104 SHALL behave as unmapped (reads 0 with rvalid=1, writes ignored).

Verification
REQ-034 SHALL cover: reset; we addr=FFFF0000 wdata=FFFF1234 -> hex_val=16'h1234 the next cycle; re to the same address -> rdata=32'h00001234 with rvalid=1 exactly one cycle later.
REQ-035 SHALL cover: DEBOUNCE_CYCLES=16; hold key_n[2]=0 for 30 cycles -> KEY reads 32'h4 once synchronization plus 16 cycles have elapsed; a glitch of key_n[2]=0 lasting 10 cycles -> KEY stays 0.
REQ-036 SHALL cover (NIU32_MMIO_EDGE_EN defined): press key 1 -> KEY_EDGE=32'h2; write 32'h2 -> KEY_EDGE=0; a write-1-to-clear in the same cycle as a key-0 press event -> bit 0 stays 1.
REQ-037 SHALL cover: we to FFFF0120 with wdata=3FF while sw=10'h155 -> read SWITCH returns 32'h155; ledr and ledg unchanged.
REQ-038 SHALL cover: re addr=FFFF0020 with reset asserted in the following cycle -> rvalid=0 and rdata=0; ledr=0; io_sel=0 for addr=00000100.
REQ-039 SHALL cover (NIU32_MMIO_EDGE_EN undefined): read FFFF0104 -> rdata=0 with rvalid=1.

Source files
------------

// File: rtl/niu32_mmio.sv
// -----------------------------------------------------------------------------
// niu32_mmio -- memory-mapped board I/O unit for a 32-bit CPU.
//
// Register map (full 32-bit address compare):
//   FFFF0000 HEX      R/W [15:0]   seven-segment nibbles
//   FFFF0020 LEDR     R/W [9:0]    red LEDs
//   FFFF0040 LEDG     R/W [7:0]    green LEDs
//   FFFF0100 KEY      RO  [3:0]    debounced pressed state (1 = pressed)
//   FFFF0104 KEY_EDGE W1C [3:0]    sticky press flags (only with NIU32_MMIO_EDGE_EN)
//   FFFF0120 SWITCH   RO  [9:0]    synchronized switches
//
// Optional feature macro: NIU32_MMIO_EDGE_EN. This macro enables the KEY_EDGE
// register. Without it, FFFF0104 decodes as unmapped.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   addr, wdata, we, re  CPU access; reads complete one cycle later
//   rdata, rvalid        registered read data and its 1-cycle valid pulse
//   io_sel               combinational, 1 for the FFFF_xxxx I/O window
//   key_n, sw            raw asynchronous board inputs
//   hex_val, ledr, ledg  registered board outputs
// -----------------------------------------------------------------------------
module niu32_mmio #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        io_sel,
    input  logic [3:0]  key_n,
    input  logic [9:0]  sw,
    output logic [15:0] hex_val,
    output logic [9:0]  ledr,
    output logic [7:0]  ledg
);

    localparam logic [31:0] ADDR_HEX      = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_LEDR     = 32'hFFFF_0020;
    localparam logic [31:0] ADDR_LEDG     = 32'hFFFF_0040;
    localparam logic [31:0] ADDR_KEY      = 32'hFFFF_0100;
    localparam logic [31:0] ADDR_KEY_EDGE = 32'hFFFF_0104;
    localparam logic [31:0] ADDR_SWITCH   = 32'hFFFF_0120;
    localparam logic [15:0] DEB_LAST      = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    logic [3:0]  key_meta_r, key_sync_r;
    logic [9:0]  sw_meta_r, sw_sync_r;
    logic [15:0] hex_r;
    logic [9:0]  ledr_r;
    logic [7:0]  ledg_r;
    logic [31:0] rdata_r, rdata_nxt_s;
    logic        rvalid_r;
    deb_state_t  state_r [4];
    deb_state_t  state_nxt_s [4];
    logic [15:0] cnt_r [4];
    logic [15:0] cnt_nxt_s [4];
    logic [3:0]  press_evt_s;
    logic [3:0]  key_pressed_s;
    logic        unused_s;

    // Upper store-data bits are never stored anywhere.
    assign unused_s = ^wdata[31:16];

    assign io_sel  = (addr[31:16] == 16'hFFFF);
    assign rdata   = rdata_r;
    assign rvalid  = rvalid_r;
    assign hex_val = hex_r;
    assign ledr    = ledr_r;
    assign ledg    = ledg_r;

    // Two-flop synchronizers; keys idle high (released), switches idle low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta_r <= 4'hF;
            key_sync_r <= 4'hF;
            sw_meta_r  <= 10'h000;
            sw_sync_r  <= 10'h000;
        end else begin
            key_meta_r <= key_n;
            key_sync_r <= key_meta_r;
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Per-key debounce next state; key_sync_r is active-low.
    always_comb begin
        press_evt_s = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            state_nxt_s[n] = state_r[n];
            cnt_nxt_s[n]   = cnt_r[n];
            case (state_r[n])
                RELEASED: begin
                    if (!key_sync_r[n]) begin
                        state_nxt_s[n] = PRESS_WAIT;
                        cnt_nxt_s[n]   = 16'd0;
                    end else begin
                        state_nxt_s[n] = RELEASED;
                    end
                end
                PRESS_WAIT: begin
                    if (key_sync_r[n]) begin
                        state_nxt_s[n] = RELEASED;
                        cnt_nxt_s[n]   = 16'd0;
                    end else if (cnt_r[n] == DEB_LAST) begin
                        state_nxt_s[n] = PRESSED;
                        cnt_nxt_s[n]   = 16'd0;
                        press_evt_s[n] = 1'b1;
                    end else begin
                        cnt_nxt_s[n] = cnt_r[n] + 16'd1;
                    end
                end
                PRESSED: begin
                    if (key_sync_r[n]) begin
                        state_nxt_s[n] = RELEASE_WAIT;
                        cnt_nxt_s[n]   = 16'd0;
                    end else begin
                        state_nxt_s[n] = PRESSED;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_sync_r[n]) begin
                        state_nxt_s[n] = PRESSED;
                        cnt_nxt_s[n]   = 16'd0;
                    end else if (cnt_r[n] == DEB_LAST) begin
                        state_nxt_s[n] = RELEASED;
                        cnt_nxt_s[n]   = 16'd0;
                    end else begin
                        cnt_nxt_s[n] = cnt_r[n] + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s[n] = RELEASED;
                    cnt_nxt_s[n]   = 16'd0;
                end
            endcase
        end
    end

    // Debounce state and counter registers for all four keys.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                state_r[n] <= RELEASED;
                cnt_r[n]   <= 16'd0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_r[n] <= state_nxt_s[n];
                cnt_r[n]   <= cnt_nxt_s[n];
            end
        end
    end

    // KEY reads 1 from the moment a press is accepted until a release is.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            key_pressed_s[n] = (state_r[n] == PRESSED) || (state_r[n] == RELEASE_WAIT);
        end
    end

    // Writable output registers; RO and unmapped writes fall through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_r  <= 16'h0000;
            ledr_r <= 10'h000;
            ledg_r <= 8'h00;
        end else if (we) begin
            case (addr)
                ADDR_HEX:  hex_r  <= wdata[15:0];
                ADDR_LEDR: ledr_r <= wdata[9:0];
                ADDR_LEDG: ledg_r <= wdata[7:0];
                default: begin
                    hex_r  <= hex_r;
                    ledr_r <= ledr_r;
                    ledg_r <= ledg_r;
                end
            endcase
        end else begin
            hex_r  <= hex_r;
            ledr_r <= ledr_r;
            ledg_r <= ledg_r;
        end
    end

`ifdef NIU32_MMIO_EDGE_EN
    logic [3:0] key_edge_r;
    logic [3:0] edge_clr_s;

    // Write-1-to-clear mask for the sticky flags.
    always_comb begin
        edge_clr_s = 4'b0000;
        if (we && (addr == ADDR_KEY_EDGE)) begin
            edge_clr_s = wdata[3:0];
        end else begin
            edge_clr_s = 4'b0000;
        end
    end

    // Sticky press flags; OR-ing the event in last lets a press beat a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_edge_r <= 4'b0000;
        end else begin
            key_edge_r <= (key_edge_r & ~edge_clr_s) | press_evt_s;
        end
    end
`else
    logic unused_evt_s;
    assign unused_evt_s = ^press_evt_s;
`endif

    // Read mux samples current register values, so a same-cycle write is not seen.
    always_comb begin
        rdata_nxt_s = 32'h0000_0000;
        case (addr)
            ADDR_HEX:      rdata_nxt_s = {16'h0000, hex_r};
            ADDR_LEDR:     rdata_nxt_s = {22'h000000, ledr_r};
            ADDR_LEDG:     rdata_nxt_s = {24'h000000, ledg_r};
            ADDR_KEY:      rdata_nxt_s = {28'h0000000, key_pressed_s};
`ifdef NIU32_MMIO_EDGE_EN
            ADDR_KEY_EDGE: rdata_nxt_s = {28'h0000000, key_edge_r};
`endif
            ADDR_SWITCH:   rdata_nxt_s = {22'h000000, sw_sync_r};
            default:       rdata_nxt_s = 32'h0000_0000;
        endcase
    end

    // Read response: one-cycle latency, rdata holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r  <= 32'h0000_0000;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= re;
            if (re) begin
                rdata_r <= rdata_nxt_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

endmodule

// File: tb/tb_niu32_mmio.sv
// -----------------------------------------------------------------------------
// tb_niu32_mmio -- self-checking bench for niu32_mmio (DEBOUNCE_CYCLES = 16).
// Read expectations are queued when a read is issued; a monitor pops and
// compares them whenever rvalid is seen. Output ports are checked directly.
// -----------------------------------------------------------------------------
module tb_niu32_mmio;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic        io_sel;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [15:0] hex_val;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] A_HEX  = 32'hFFFF_0000;
    localparam logic [31:0] A_LEDR = 32'hFFFF_0020;
    localparam logic [31:0] A_LEDG = 32'hFFFF_0040;
    localparam logic [31:0] A_KEY  = 32'hFFFF_0100;
    localparam logic [31:0] A_EDGE = 32'hFFFF_0104;
    localparam logic [31:0] A_SW   = 32'hFFFF_0120;

    niu32_mmio #(.DEBOUNCE_CYCLES(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .io_sel  (io_sel),
        .key_n   (key_n),
        .sw      (sw),
        .hex_val (hex_val),
        .ledr    (ledr),
        .ledg    (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid actual=%h required=none", rdata);
            end else begin
                chk("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a; re = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        re = 1'b0;
        chk("rvalid_latency", {31'd0, rvalid}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
        key_n = 4'hF; sw = 10'h000;
        repeat (3) @(negedge clk);
        chk("reset_hex",    {16'd0, hex_val}, 32'h0);
        chk("reset_ledr",   {22'd0, ledr},    32'h0);
        chk("reset_ledg",   {24'd0, ledg},    32'h0);
        chk("reset_rvalid", {31'd0, rvalid},  32'h0);
        chk("reset_rdata",  rdata,            32'h0);
        reset = 1'b0;

        // Basic R/W registers, upper data bits dropped.
        do_write(A_HEX, 32'hFFFF_1234);
        chk("hex_after_write", {16'd0, hex_val}, 32'h0000_1234);
        do_read(A_HEX, 32'h0000_1234);
        do_write(A_LEDR, 32'hFFFF_FABC);
        chk("ledr_after_write", {22'd0, ledr}, 32'h0000_02BC);
        do_write(A_LEDG, 32'h0000_01A5);
        chk("ledg_after_write", {24'd0, ledg}, 32'h0000_00A5);
        do_read(A_LEDR, 32'h0000_02BC);
        do_read(A_LEDG, 32'h0000_00A5);

        // SWITCH is read-only and reflects synchronized sw.
        sw = 10'h155;
        repeat (3) @(negedge clk);
        do_write(A_SW, 32'h0000_03FF);
        chk("ledr_unchanged", {22'd0, ledr}, 32'h0000_02BC);
        chk("ledg_unchanged", {24'd0, ledg}, 32'h0000_00A5);
        do_read(A_SW, 32'h0000_0155);

        // Unmapped read and write.
        do_read(32'h0000_1234, 32'h0);
        do_write(32'hFFFF_0200, 32'hFFFF_FFFF);
        chk("hex_unmapped_wr", {16'd0, hex_val}, 32'h0000_1234);
        chk("ledr_unmapped_wr", {22'd0, ledr}, 32'h0000_02BC);

        // Same-cycle write and read return the pre-write value.
        @(negedge clk);
        addr = A_HEX; wdata = 32'h0000_5678; we = 1'b1; re = 1'b1;
        exp_q.push_back(32'h0000_1234);
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("hex_after_rw", {16'd0, hex_val}, 32'h0000_5678);

        // io_sel decode.
        addr = 32'h0000_0100; #1;
        chk("io_sel_low", {31'd0, io_sel}, 32'h0);
        addr = A_LEDR; #1;
        chk("io_sel_high", {31'd0, io_sel}, 32'h1);

        // Key 2 held 30 cycles: not yet accepted after 10, accepted after 30.
        @(negedge clk);
        key_n = 4'b1011;
        repeat (9) @(negedge clk);
        do_read(A_KEY, 32'h0);
        repeat (17) @(negedge clk);
        do_read(A_KEY, 32'h0000_0004);
        key_n = 4'hF;
        repeat (40) @(negedge clk);
        do_read(A_KEY, 32'h0);

        // 10-cycle glitch never reaches PRESSED.
        key_n = 4'b1011;
        repeat (10) @(negedge clk);
        key_n = 4'hF;
        do_read(A_KEY, 32'h0);
        repeat (30) @(negedge clk);
        do_read(A_KEY, 32'h0);

`ifdef NIU32_MMIO_EDGE_EN
        // Flush bit 2 from the earlier key-2 press.
        do_read(A_EDGE, 32'h0000_0004);
        do_write(A_EDGE, 32'h0000_000F);
        do_read(A_EDGE, 32'h0);
        // Key 1 press sets its flag; W1C clears it.
        key_n = 4'b1101;
        repeat (30) @(negedge clk);
        do_read(A_EDGE, 32'h0000_0002);
        do_write(A_EDGE, 32'h0000_0002);
        do_read(A_EDGE, 32'h0);
        key_n = 4'hF;
        repeat (40) @(negedge clk);
        // Key 0 press event coincides with a clear of bit 0: set wins.
        // Driven at negedge N0, the event fires on the 19th rising edge.
        key_n = 4'b1110;
        repeat (18) @(posedge clk);
        do_write(A_EDGE, 32'h0000_0001);
        do_read(A_EDGE, 32'h0000_0001);
        key_n = 4'hF;
        repeat (40) @(negedge clk);
`else
        do_write(A_EDGE, 32'h0000_000F);
        do_read(A_EDGE, 32'h0);
`endif

        // Reset lands while a read is in flight: the read is dropped.
        @(negedge clk);
        addr = A_LEDR; re = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        re = 1'b0;
        chk("mid_reset_rvalid", {31'd0, rvalid}, 32'h0);
        chk("mid_reset_rdata",  rdata,           32'h0);
        chk("mid_reset_ledr",   {22'd0, ledr},   32'h0);
        chk("mid_reset_hex",    {16'd0, hex_val}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rvalid", {31'd0, rvalid}, 32'h0);
        @(negedge clk);
        chk("post_reset_rvalid2", {31'd0, rvalid}, 32'h0);

        // Normal operation resumes.
        do_write(A_HEX, 32'h0000_BEEF);
        do_read(A_HEX, 32'h0000_BEEF);
        repeat (2) @(negedge clk);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
